phase_scheduler: RTL
====================

# phase_scheduler

Sequencing controller for the intersection's highway/farm-road signal heads. It arbitrates between three requesters: the farm-road vehicle sensor, a latched pedestrian button and an emergency pre-empt. It enforces minimum green, maximum green, yellow and all-red clearance intervals on a 1 Hz enable. Its light codes, state and countdown feed the existing SSD display path (light decoder, state digit, BCD timer digits).

## Interface

Parameters:
- MIN_GREEN_HY, 10, minimum highway green, seconds (≥1)
- MAX_GREEN_FR, 15, maximum farm-road green, seconds (≥ WALK)
- YELLOW, 5, yellow interval, seconds (≥1)
- ALL_RED, 2, all-red clearance, seconds (≥1)
- WALK, 8, pedestrian walk interval, seconds (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-low
- Tick  in  1  one-Clk-wide 1 Hz enable; all timing advances only on Tick
- FarmReq  in  1  farm-road vehicle sensor, level
- PedBtn  in  1  pedestrian button, level; a set is latched on any cycle it is high
- EmgReq  in  1  emergency pre-empt toward highway, level
- hy  out  2  highway light: G=0, Yw=1, R=2
- fr  out  2  farm-road light, same encoding
- state  out  3  current phase code
- count  out  8  seconds remaining in current interval
- PedWalk  out  1  walk indication, crossing the highway

## Operation

- States and codes: HG=0 (hy G, fr R), HY=1 (hy Yw, fr R), AR1=2 (both R), FG=3 (hy R, fr G), FY=4 (hy R, fr Yw), AR2=5 (both R). Codes 6 and 7 are illegal and go to HG on the next Clk.
- On state entry, count loads duration−1: HG→MIN_GREEN_HY, HY/FY→YELLOW, AR1/AR2→ALL_RED, FG→MAX_GREEN_FR. On Tick with count>0, count decrements. A Tick with count==0 marks the interval as expired.
- PedPend: set by PedBtn; cleared on the Clk that enters FG. When a set and a clear coincide, the request counts as served and the latch is cleared. On entry to FG with PedPend=1, the walk counter loads WALK−1 and PedWalk=1. PedWalk clears on the Tick where the walk counter is 0, or on leaving FG.
- HG: after expiry, count holds at 0. Go to HY on a Tick with expiry met, (FarmReq or PedPend) high and EmgReq=0.
- HY→AR1, AR1→FG, FY→AR2, AR2→HG: on the expiring Tick.
- FG→FY on a Tick when any of these holds:
  - interval expired;
  - EmgReq=1, checked immediately without minimum;
  - FarmReq=0 and PedWalk=0, for early gap-out.
- EmgReq in HY, AR1 or FY/AR2 does not shorten clearance intervals. While EmgReq=1 in AR1, the AR1→FG step is replaced by AR1→AR2.
- Priority: Reset > EmgReq > expiry/gap-out > requests.

## Timing

- Reset values (next Clk edge with Reset=0): state=HG, hy=0, fr=2, count=MIN_GREEN_HY−1, PedWalk=0, PedPend=0, walk counter=0.
- Reset mid-interval aborts immediately. Reset has no Tick dependence.
- All outputs are registered. Outputs change on the Clk edge after the Tick that causes the transition, with 1-cycle latency.
- Each non-HG phase lasts exactly its duration in Ticks, unless ended early (FG only).
- A PedBtn pulse of one Clk, anywhere, is never lost.
- count never underflows. It is 8-bit; parameters must be ≤255.

## Structure

- Shared package traffic_pkg: light codes (G, Yw, R) and the phase codes HG..AR2, used by the SSD state/light decoders too.
- Sub-module phase_timer: loadable 8-bit down counter with Tick enable, load value, and an expired flag. There are two instances, one for phase and one for walk.
- The scheduler FSM, PedPend latch and output register stay in phase_scheduler.

## Test plan

- Reset released, no requests, 30 Ticks → state stays 0, hy=0, fr=2, count reaches 0 after 9 Ticks and holds.
- FarmReq held high from reset → HG for 10 Ticks, HY 5, AR1 2, FG 15, FY 5, AR2 2, back to HG. The state sequence 0,1,2,3,4,5,0 and count reloads are checked.
- One-Clk PedBtn pulse at Tick 3, FarmReq=0 → HY after Tick 10, later FG with PedWalk=1 for 8 Ticks. FG gaps out on the Tick after PedWalk falls (FG lasts 9 Ticks).
- EmgReq raised at FG count=12 → FY on the next Tick, full YELLOW and ALL_RED, then HG. EmgReq held keeps HG.
- EmgReq raised during AR1 → AR1 completes 2 Ticks, goes to AR2 (state 5), then HG. FG is never entered.
- Reset asserted in FY with count=3 → next edge state=0, count=9, PedPend=0. A PedBtn in the same cycle as FG entry leaves PedPend=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared light and phase codes for the intersection controller.
// Also used by the SSD state digit and light decoders.
package traffic_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        LIGHT_G  = 2'd0,
        LIGHT_YW = 2'd1,
        LIGHT_R  = 2'd2
    } light_e;

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        FG  = 3'd3,
        FY  = 3'd4,
        AR2 = 3'd5
    } phase_e;

    function automatic light_e hy_light(input phase_e p);
        case (p)
            HG:      return LIGHT_G;
            HY:      return LIGHT_YW;
            default: return LIGHT_R;
        endcase
    endfunction

    function automatic light_e fr_light(input phase_e p);
        case (p)
            FG:      return LIGHT_G;
            FY:      return LIGHT_YW;
            default: return LIGHT_R;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter advancing on the 1 Hz enable.
// Saturates at zero; expired marks a Tick seen at zero.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load wins over countdown; hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (Tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // counter register, synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign expired = Tick && (cnt_q == '0);

endmodule

// File: rtl/phase_scheduler.sv
// Highway/farm-road phase sequencer with pedestrian and
// emergency pre-empt arbitration; all outputs registered.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN_HY = 10,
    parameter int MAX_GREEN_FR = 15,
    parameter int YELLOW       = 5,
    parameter int ALL_RED      = 2,
    parameter int WALK         = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       FarmReq,
    input  logic       PedBtn,
    input  logic       EmgReq,
    output logic [1:0] hy,
    output logic [1:0] fr,
    output logic [2:0] state,
    output logic [7:0] count,
    output logic       PedWalk
);

    phase_e     state_q, state_d;
    light_e     hy_q, hy_d;
    light_e     fr_q, fr_d;
    logic       ped_pend_q, ped_pend_d;
    logic       ped_walk_q, ped_walk_d;

    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] ph_val;
    logic             ph_exp;
    logic             ph_load;
    logic [CNT_W-1:0] wk_cnt;
    logic             wk_exp;
    logic             wk_load;
    logic             fg_entry;
    logic             served;
    logic             unused_wk;

    function automatic logic [CNT_W-1:0] dur_m1(input phase_e p);
        case (p)
            HY, FY:   return CNT_W'(YELLOW - 1);
            AR1, AR2: return CNT_W'(ALL_RED - 1);
            FG:       return CNT_W'(MAX_GREEN_FR - 1);
            default:  return CNT_W'(MIN_GREEN_HY - 1);
        endcase
    endfunction

    phase_timer #(
        .RST_VAL (CNT_W'(MIN_GREEN_HY - 1))
    ) u_phase (
        .Clk      (Clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .load     (ph_load),
        .load_val (ph_val),
        .count    (ph_cnt),
        .expired  (ph_exp)
    );

    phase_timer #(
        .RST_VAL ('0)
    ) u_walk (
        .Clk      (Clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .load     (wk_load),
        .load_val (CNT_W'(WALK - 1)),
        .count    (wk_cnt),
        .expired  (wk_exp)
    );

    // walk length is only needed through its expiry flag
    assign unused_wk = ^wk_cnt;

    // next phase: emergency first, then expiry/gap-out, then requests
    always_comb begin
        state_d = state_q;
        case (state_q)
            HG: begin
                if (ph_exp && (FarmReq || ped_pend_q) && !EmgReq)
                    state_d = HY;
            end
            HY: begin
                if (ph_exp) state_d = AR1;
            end
            AR1: begin
                if (ph_exp) state_d = EmgReq ? AR2 : FG;
            end
            FG: begin
                if (ph_exp || (Tick && (EmgReq ||
                    (!FarmReq && !ped_walk_q))))
                    state_d = FY;
            end
            FY: begin
                if (ph_exp) state_d = AR2;
            end
            AR2: begin
                if (ph_exp) state_d = HG;
            end
            default: state_d = HG;
        endcase
    end

    // timer reloads, pedestrian latch/walk, and light codes
    always_comb begin
        ph_load    = (state_d != state_q);
        ph_val     = dur_m1(state_d);
        fg_entry   = (state_d == FG) && (state_q != FG);
        served     = ped_pend_q || PedBtn;
        ped_pend_d = fg_entry ? 1'b0 : served;
        wk_load    = fg_entry && served;
        ped_walk_d = ped_walk_q;
        if (wk_exp) ped_walk_d = 1'b0;
        if (state_d != FG) ped_walk_d = 1'b0;
        if (fg_entry) ped_walk_d = served;
        hy_d = hy_light(state_d);
        fr_d = fr_light(state_d);
    end

    // phase and output register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= HG;
            hy_q       <= LIGHT_G;
            fr_q       <= LIGHT_R;
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hy_q       <= hy_d;
            fr_q       <= fr_d;
            ped_pend_q <= ped_pend_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign hy      = hy_q;
    assign fr      = fr_q;
    assign state   = state_q;
    assign count   = ph_cnt;
    assign PedWalk = ped_walk_q;

endmodule
